// File: rtl/matmul_seq_ctrl_if.sv
// Y-buffer write channel of matmul_seq_ctrl: FIFO head presented with a ready handshake.
interface matmul_seq_ctrl_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16
);
   logic                  y_wr_en;
   logic [ADDR_WIDTH-1:0] y_wr_addr;
   logic [DATA_WIDTH-1:0] y_wr_data;
   logic                  y_wr_ready;

   modport master (output y_wr_en, output y_wr_addr, output y_wr_data, input y_wr_ready);
   modport slave  (input y_wr_en, input y_wr_addr, input y_wr_data, output y_wr_ready);
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Sequences an HxW by WxP fixed-point product through a W-lane multiplier array, one element per cycle.
// Define MATMUL_RELU_EN to clamp negative saturated sums to zero before they enter the output FIFO.
module matmul_seq_ctrl #(
   parameter int H           = 8,
   parameter int W           = 8,
   parameter int P           = 8,
   parameter int DATA_WIDTH  = 16,
   parameter int FRACT_WIDTH = 8,
   parameter int DOT_LAT     = 2,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic                       ovf,
   output logic                       a_rd_en,
   output logic [$clog2(H)-1:0]       a_rd_addr,
   input  logic [W*DATA_WIDTH-1:0]    a_rd_data,
   output logic                       b_rd_en,
   output logic [$clog2(P)-1:0]       b_rd_addr,
   input  logic [W*DATA_WIDTH-1:0]    b_rd_data,
   output logic [W*DATA_WIDTH-1:0]    dot_a,
   output logic [W*DATA_WIDTH-1:0]    dot_b,
   input  logic [W*DATA_WIDTH-1:0]    dot_prod,
   input  logic [W-1:0]               dot_ovf,
   matmul_seq_ctrl_if.master          y
);

   localparam int RW  = $clog2(H);
   localparam int CLW = $clog2(P);
   localparam int AW  = $clog2(H * P);
   localparam int DW  = DATA_WIDTH;
   localparam int SW  = DW + $clog2(W);
   localparam int NST = DOT_LAT + 2;
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int CW1 = CW + 1;

   localparam logic signed [SW-1:0] SMAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [SW-1:0] SMIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   // A misconfigured instance never issues, so it can neither overrun the FIFO nor emit garbage.
   localparam bit CFG_OK = (FIFO_DEPTH >= DOT_LAT + 4) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0) &&
                           (FRACT_WIDTH < DATA_WIDTH) && (DOT_LAT >= 0);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                state;
   logic [RW-1:0]         row;
   logic [CLW-1:0]        col;
   logic [NST-1:0]        vld;
   logic [AW-1:0]         addr_pipe [NST];
   logic [CW-1:0]         inflight;
   logic [CW-1:0]         count;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [AW+DW-1:0]      mem [FIFO_DEPTH];
   logic [AW+DW-1:0]      head;
   logic signed [DW-1:0]  sum_q;
   logic signed [SW-1:0]  acc;
   logic signed [DW-1:0]  res;
   logic                  sat;
   logic                  room;
   logic                  issue;
   logic                  push;
   logic                  pop;

   // Credit check ignores a same-cycle pop so the FIFO can never be over-committed.
   assign room  = (CW1'(inflight) + CW1'(count)) < CW1'(FIFO_DEPTH);
   assign issue = CFG_OK && (state == S_RUN) && room;
   assign push  = vld[NST-1];
   assign pop   = y.y_wr_en && y.y_wr_ready;

   assign a_rd_en   = issue;
   assign b_rd_en   = issue;
   assign a_rd_addr = row;
   assign b_rd_addr = col;
   assign dot_a     = (state == S_IDLE) ? '0 : a_rd_data;
   assign dot_b     = (state == S_IDLE) ? '0 : b_rd_data;

   assign head        = mem[rd_ptr];
   assign y.y_wr_en   = (count != '0);
   assign y.y_wr_addr = y.y_wr_en ? head[AW+DW-1:DW] : '0;
   assign y.y_wr_data = y.y_wr_en ? head[DW-1:0] : '0;

   always_comb begin
      acc = '0;
      for (int unsigned k = 0; k < W; k++) begin
         acc = acc + SW'($signed(dot_prod[k*DW +: DW]));
      end
      sat = 1'b0;
      res = acc[DW-1:0];
      if (acc > SMAX) begin
         res = SMAX[DW-1:0];
         sat = 1'b1;
      end else if (acc < SMIN) begin
         res = SMIN[DW-1:0];
         sat = 1'b1;
      end
`ifdef MATMUL_RELU_EN
      if (res[DW-1]) begin
         res = '0;
      end
`else
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
      end else begin
         vld <= {vld[NST-2:0], issue};
      end
   end

   always_ff @(posedge clk) begin
      addr_pipe[0] <= AW'(row) * AW'(P) + AW'(col);
      for (int unsigned i = 1; i < NST; i++) begin
         addr_pipe[i] <= addr_pipe[i-1];
      end
      if (vld[DOT_LAT]) begin
         sum_q <= res;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {addr_pipe[NST-1], sum_q};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         inflight <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         case ({issue, push})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         row   <= '0;
         col   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (vld[DOT_LAT] && ((|dot_ovf) || sat)) begin
            ovf <= 1'b1;
         end
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_RUN;
                  row   <= '0;
                  col   <= '0;
                  ovf   <= 1'b0;
                  busy  <= 1'b1;
               end
            end
            S_RUN: begin
               if (issue) begin
                  if (col == CLW'(P - 1)) begin
                     col <= '0;
                     if (row == RW'(H - 1)) begin
                        state <= S_DRAIN;
                     end else begin
                        row <= row + 1'b1;
                     end
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               // Leave as the final write is accepted so done lands on the very next cycle.
               if ((inflight == '0) && ((count == '0) || ((count == CW'(1)) && pop))) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench for matmul_seq_ctrl: directed and random matrices checked against a plain matrix-product model.
module tb_matmul_seq_ctrl;
   localparam int H  = 8;
   localparam int W  = 8;
   localparam int P  = 8;
   localparam int DW = 16;
   localparam int AW = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              busy, done, ovf;
   logic              a_rd_en, b_rd_en;
   logic [2:0]        a_rd_addr, b_rd_addr;
   logic [W*DW-1:0]   a_rd_data, b_rd_data, dot_a, dot_b, dot_prod;
   logic [W-1:0]      dot_ovf;
   logic [W*DW-1:0]   s1_p, s2_p;
   logic [W-1:0]      s1_o, s2_o;

   matmul_seq_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) yif();

   matmul_seq_ctrl #(
      .H(H), .W(W), .P(P), .DATA_WIDTH(DW), .FRACT_WIDTH(8), .DOT_LAT(2), .FIFO_DEPTH(8)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .ovf(ovf),
      .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
      .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
      .dot_a(dot_a), .dot_b(dot_b), .dot_prod(dot_prod), .dot_ovf(dot_ovf),
      .y(yif)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   logic signed [DW-1:0] A [H][W];
   logic signed [DW-1:0] B [W][P];
   exp_t                 exp_q[$];
   exp_t                 mon_e;
   bit                   exp_ovf;
   int                   n_checks = 0;
   int                   n_err = 0;
   int                   cyc = 0;
   int                   start_cyc, stall_win;
   int                   acc_n, done_n, first_en, first_acc, last_acc, done_cyc, blk_issues;
   bit                   prev_stall = 1'b0;
   logic [AW-1:0]        prev_addr;
   logic [DW-1:0]        prev_data;

   always @(posedge clk) cyc <= cyc + 1;

   // Lane array stand-in: Q8.8 multiply, truncate to 16 bits, flag if the true value does not fit.
   function automatic void lane_mul(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                                    output logic [DW-1:0] p, output logic o);
      int full;
      full = (int'(a) * int'(b)) >>> 8;
      p = full[DW-1:0];
      o = (full > 32767) || (full < -32768);
   endfunction

   always @(posedge clk) begin
      logic [DW-1:0] pk;
      logic          lo;
      for (int k = 0; k < W; k++) begin
         lane_mul(dot_a[k*DW +: DW], dot_b[k*DW +: DW], pk, lo);
         s1_p[k*DW +: DW] <= pk;
         s1_o[k]          <= lo;
      end
      s2_p <= s1_p;
      s2_o <= s1_o;
   end
   assign dot_prod = s2_p;
   assign dot_ovf  = s2_o;

   always @(posedge clk) begin
      if (a_rd_en) for (int k = 0; k < W; k++) a_rd_data[k*DW +: DW] <= A[a_rd_addr][k];
      if (b_rd_en) for (int k = 0; k < W; k++) b_rd_data[k*DW +: DW] <= B[k][b_rd_addr];
   end

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // Y = A*B row-major, each lane truncated as the lanes deliver it, then saturated (and clamped if ReLU).
   function automatic void build_expected();
      logic [DW-1:0] p;
      logic          o;
      int            s;
      exp_q.delete();
      exp_ovf = 1'b0;
      for (int i = 0; i < H; i++) begin
         for (int j = 0; j < P; j++) begin
            s = 0;
            for (int k = 0; k < W; k++) begin
               lane_mul(A[i][k], B[k][j], p, o);
               s += int'($signed(p));
               if (o) exp_ovf = 1'b1;
            end
            if (s > 32767) begin
               s = 32767;
               exp_ovf = 1'b1;
            end else if (s < -32768) begin
               s = -32768;
               exp_ovf = 1'b1;
            end
`ifdef MATMUL_RELU_EN
            if (s < 0) s = 0;
`endif
            exp_q.push_back('{addr: AW'(i * P + j), data: DW'(s)});
         end
      end
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (a_rd_en && ((cyc - start_cyc) <= stall_win)) blk_issues++;
         if (yif.y_wr_en && first_en < 0) first_en = cyc;
         if (prev_stall && yif.y_wr_en)
            check("y_hold", {yif.y_wr_addr, yif.y_wr_data}, {prev_addr, prev_data});
         prev_stall = yif.y_wr_en && !yif.y_wr_ready;
         prev_addr  = yif.y_wr_addr;
         prev_data  = yif.y_wr_data;
         if (yif.y_wr_en && yif.y_wr_ready) begin
            acc_n++;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL stale_write addr=%0d data=%0h expected no write", yif.y_wr_addr, yif.y_wr_data);
            end else begin
               mon_e = exp_q.pop_front();
               check("y_write", {yif.y_wr_addr, yif.y_wr_data}, {mon_e.addr, mon_e.data});
            end
         end
         if (done) begin
            done_n++;
            done_cyc = cyc;
         end
      end
   end

   task automatic check_idle_outputs(input string nm);
      check({nm, "_ctrl"}, 64'({busy, done, ovf, a_rd_en, b_rd_en, yif.y_wr_en}), 64'd0);
      check({nm, "_addr"}, 64'({a_rd_addr, b_rd_addr, yif.y_wr_addr}), 64'd0);
      check({nm, "_ydata"}, 64'(yif.y_wr_data), 64'd0);
      check({nm, "_dot"}, 64'({|dot_a, |dot_b}), 64'd0);
   endtask

   task automatic set_diag(input logic signed [DW-1:0] d);
      for (int i = 0; i < H; i++)
         for (int k = 0; k < W; k++) A[i][k] = (i == k) ? d : '0;
      for (int k = 0; k < W; k++)
         for (int j = 0; j < P; j++) B[k][j] = DW'((k * 8 + j) << 8);
   endtask

   task automatic set_const(input logic signed [DW-1:0] v);
      for (int i = 0; i < H; i++)
         for (int k = 0; k < W; k++) begin
            A[i][k] = v;
            B[i][k] = v;
         end
   endtask

   task automatic set_rand(input int lim);
      for (int i = 0; i < H; i++)
         for (int k = 0; k < W; k++) begin
            A[i][k] = (lim == 0) ? DW'($urandom) : DW'(int'($urandom_range(0, 2 * lim)) - lim);
            B[i][k] = (lim == 0) ? DW'($urandom) : DW'(int'($urandom_range(0, 2 * lim)) - lim);
         end
   endtask

   // stall: ready held low for run cycles 0..stall (-1 none); rst_at: reset the run at that cycle (0 none).
   task automatic run_case(input int stall, input bit rnd_rdy, input bit extra_starts, input int rst_at);
      int rel;
      bit fin;
      build_expected();
      acc_n = 0; done_n = 0; first_en = -1; first_acc = -1; last_acc = -1; done_cyc = -1; blk_issues = 0;
      stall_win = stall;
      start_cyc = cyc;
      rel = 0;
      fin = 1'b0;
      while (!fin) begin
         start = (rel == 0) || (extra_starts && (rel == 3 || rel == 20));
         rst   = (rst_at > 0) && (rel == rst_at);
         if (rel <= stall)  yif.y_wr_ready = 1'b0;
         else if (rnd_rdy)  yif.y_wr_ready = ($urandom_range(0, 3) != 0);
         else               yif.y_wr_ready = 1'b1;
         @(posedge clk); #1;
         rel++;
         if (rel == 1) check("ovf_clear_on_start", 64'(ovf), 64'd0);
         if (rel == 2 && rst_at != 1) check("busy_in_run", 64'(busy), 64'd1);
         if (rst_at > 0 && rel == rst_at + 1) begin
            check_idle_outputs("mid_reset");
            fin = 1'b1;
         end else if (done_n > 0) begin
            fin = 1'b1;
         end else if (rel > 2000) begin
            n_checks++;
            n_err++;
            $display("FAIL done_timeout got=no done expected=done within 2000 cycles");
            fin = 1'b1;
         end
      end
      start = 1'b0;
      rst = 1'b0;
      yif.y_wr_ready = 1'b1;
      if (rst_at > 0) begin
         exp_q.delete();
         acc_n = 0;
         done_n = 0;
         repeat (12) @(posedge clk);
         #1;
         check("post_reset_writes", 64'(acc_n), 64'd0);
         check("post_reset_done", 64'(done_n), 64'd0);
      end else begin
         repeat (6) @(posedge clk);
         #1;
         check("write_count", 64'(acc_n), 64'(H * P));
         check("queue_empty", 64'(exp_q.size()), 64'd0);
         check("done_count", 64'(done_n), 64'd1);
         check("done_after_last", 64'(done_cyc - last_acc), 64'd1);
         check("ovf", 64'(ovf), 64'(exp_ovf));
         check("busy_idle", 64'(busy), 64'd0);
         if (!rnd_rdy) check("throughput", 64'(last_acc - first_acc), 64'(H * P - 1));
         if (stall < 0) check("first_write_lat", 64'(first_en - start_cyc), 64'd6);
         if (stall >= 0) check("blocked_issues", 64'(blk_issues), 64'd8);
      end
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog got=still running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      yif.y_wr_ready = 1'b1;
      stall_win = -1;
      start_cyc = 0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      set_diag(16'sh0100);
      run_case(-1, 1'b0, 1'b0, 0);
      set_const(16'sh0B00);
      run_case(-1, 1'b0, 1'b0, 0);
      set_diag(16'sh0100);
      run_case(-1, 1'b0, 1'b0, 0);
      run_case(30, 1'b0, 1'b0, 0);
      run_case(-1, 1'b0, 1'b1, 0);
      run_case(-1, 1'b0, 1'b0, 10);
      run_case(-1, 1'b0, 1'b0, 0);
      set_diag(16'shFF00);
      run_case(-1, 1'b0, 1'b0, 0);
      set_rand(512);
      run_case(-1, 1'b1, 1'b0, 0);
      set_rand(0);
      run_case(-1, 1'b1, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Sequences one H×W by W×P fixed-point matrix product through a single W-lane multiplier array, one output element per cycle.
- Issues row and column reads to the A and B operand buffers, feeds the lanes, and reduces the W lane products with saturation.
- Queues results in an internal output FIFO and writes them to the Y buffer with ready back-pressure.
- Sits between the operand/result buffers and the qmult lane array in the CRNN compute path.

Parameters:
- H, 8: rows of A and Y.
- W, 8: inner dimension; number of multiplier lanes.
- P, 8: columns of B and Y.
- DATA_WIDTH, 16: signed element width.
- FRACT_WIDTH, 8: fractional bits. Lanes return Q-aligned products; the controller does no shifting.
- DOT_LAT, 2: fixed lane latency in cycles (at least 0).
- FIFO_DEPTH, 8: output FIFO entries. Must be a power of 2 and at least DOT_LAT+4 to sustain 1 result per cycle.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high, acts on rising clk edge
- start  in  1  begin a matrix product; sampled only in IDLE
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse after the last Y write is accepted
- ovf  out  1  sticky overflow; cleared on accepted start
- a_rd_en  out  1  A row read strobe
- a_rd_addr  out  $clog2(H)  A row index
- a_rd_data  in  W*DATA_WIDTH  A row; valid exactly 1 cycle after a_rd_en
- b_rd_en  out  1  B column read strobe
- b_rd_addr  out  $clog2(P)  B column index
- b_rd_data  in  W*DATA_WIDTH  B column (lane k = B[k][col]); valid 1 cycle after b_rd_en
- dot_a  out  W*DATA_WIDTH  lane operands A
- dot_b  out  W*DATA_WIDTH  lane operands B
- dot_prod  in  W*DATA_WIDTH  lane products, DOT_LAT cycles after dot_a/dot_b
- dot_ovf  in  W  per-lane overflow, aligned with dot_prod
- y_wr_en  out  1  FIFO head valid
- y_wr_addr  out  $clog2(H*P)  row*P+col
- y_wr_data  out  DATA_WIDTH  result element
- y_wr_ready  in  1  Y buffer accepts; a write transfers when y_wr_en && y_wr_ready

Behaviour:
- Reset values: all outputs 0. FSM goes to IDLE, row/col counters 0, FIFO empty, in-flight tracker cleared.
- Reset mid-operation: all in-flight results are discarded and no done pulse is produced.
- FSM states:
  - IDLE: on start, clear ovf and counters, go to RUN.
  - RUN: issue reads. After issuing (row H-1, col P-1), go to DRAIN.
  - DRAIN: wait for in-flight count = 0 and FIFO empty, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored.
- Issue rule (RUN): a_rd_en = b_rd_en = 1 in a cycle iff inflight + fifo_count < FIFO_DEPTH. A pop in the same cycle is not credited.
  - On issue, col increments; at P-1 it wraps to 0 and row increments.
  - Order is row-major; addresses are held while not issuing.
- Pipeline, for an issue in cycle t:
  - t+1: dot_a/dot_b are driven from a_rd_data/b_rd_data directly.
  - t+1+DOT_LAT: sum is registered.
  - t+2+DOT_LAT: sum is pushed into the FIFO.
  - t+3+DOT_LAT: y_wr_en is high, at the earliest.
  - A valid shift register of length DOT_LAT+2 tracks the in-flight elements and their addresses.
- With the defaults, the first y_wr_en is 6 cycles after the start cycle. Throughput is 1 element per cycle while y_wr_ready=1.
- Reduction:
  - Sign-extend each lane to DATA_WIDTH+$clog2(W) bits and add all W lanes.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - ovf is set if any dot_ovf bit is high on a valid cycle, or if saturation occurs.
- FIFO: simultaneous push and pop is allowed; count is unchanged. Push never occurs when full, which the issue rule guarantees.
- y_wr_addr/y_wr_data must be held stable while y_wr_en && !y_wr_ready.
- dot_a/dot_b are don't-care when not valid. They are driven to 0 in IDLE.

Optional Feature:
- Macro: MATMUL_RELU_EN.
- Defined: the saturated sum is clamped to 0 if negative, before the FIFO push. The clamp does not affect ovf.
- Undefined: signed results pass unchanged.

Test Plan:
- Defaults; bench lane model = (a*b)>>>8 with lat 2. A = identity (0x0100 on the diagonal), B[i][j] = (i*8+j)<<8.
  -> 64 writes; addresses 0..63 in order; Y == B; first write 6 cycles after start; done 1 cycle after the last accept; ovf=0.
- A = B = all 0x0B00 (11.0).
  -> every y = 0x7FFF, ovf=1. A following start with the identity test clears ovf to 0.
- Identity test with y_wr_ready=0 for cycles 0..30.
  -> a_rd_en stops once inflight+count reaches 8; no data lost; after release, 64 correct writes in order, 1 per cycle.
- start pulsed again in cycles 3 and 20 of a run.
  -> ignored; exactly 64 writes and exactly one done pulse.
- rst in cycle 10 of a run.
  -> next cycle all outputs 0, busy=0. A new start gives a full correct 64-element result with no stale writes.
- A = -identity (0xFF00 diagonal), B as in the first test.
  -> Y = -B without MATMUL_RELU_EN. With MATMUL_RELU_EN defined: Y[0] = 0 and all other Y = 0 (all negative or zero).
